conv_col_feeder: RTL and testbench

Column feeder for the AHB convolver. It walks a stored IMG_W×IMG_H image of 4-bit pixels and reads three vertically adjacent pixels per column from the sample buffer. Each time it has a full column, it pushes it into samp_shift_reg using a single-cycle shift pulse. It also flags when the shift register holds a complete 3×3 window, so the convolution core knows when to compute.

---
 rtl/conv_pkg.sv | 24 ++
 rtl/conv_col_feeder_if.sv | 33 +++
 rtl/conv_addr_gen.sv | 77 +++++++
 rtl/conv_col_feeder.sv | 126 ++++++++++++
 tb/tb_conv_col_feeder.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolver column feeder.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        R0,
        R1,
        R2,
        CAP
    } feeder_state_t;

    localparam int PIX_BITS = 4;
    localparam int COL_W    = 12;

    // Packs one column as {pad, top, middle, bottom} into the 16-bit shift word.
    function automatic logic [15:0] pack_col(
        input logic [PIX_BITS-1:0] top,
        input logic [PIX_BITS-1:0] mid,
        input logic [PIX_BITS-1:0] bot
    );
        return {{(16 - COL_W){1'b0}}, top, mid, bot};
    endfunction

endpackage

// File: rtl/conv_col_feeder_if.sv
// Sample-buffer read bus plus the column push bus into samp_shift_reg.
interface conv_col_feeder_if
    import conv_pkg::*;
#(
    parameter int ADDR_W = 6
) ();

    logic                rd_en;
    logic [ADDR_W-1:0]   rd_addr;
    logic [PIX_BITS-1:0] rd_data;
    logic                shift_en;
    logic [15:0]         col_out;
    logic                sample_valid;

    modport master (
        output rd_en,
        output rd_addr,
        input  rd_data,
        output shift_en,
        output col_out,
        output sample_valid
    );

    modport slave (
        input  rd_en,
        input  rd_addr,
        output rd_data,
        input  shift_en,
        input  col_out,
        input  sample_valid
    );

endinterface

// File: rtl/conv_addr_gen.sv
// Window row / column counters and buffer address generation for the feeder.
// Addresses are formed from a running row base (r*IMG_W) so no multiplier is
// needed; the address is computed from the post-advance counter values so the
// caller can register it in the same cycle the counters move.
module conv_addr_gen
    import conv_pkg::*;
#(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int ADDR_W = $clog2(IMG_W * IMG_H)
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              advance,
    input  logic [1:0]        row_sel,
    output logic [ADDR_W-1:0] addr,
    output logic              last_col,
    output logic              col_ge2
);

    localparam logic [ADDR_W-1:0] W_STEP = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] C_MAX  = ADDR_W'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] R_MAX  = ADDR_W'(IMG_H - 3);

    logic [ADDR_W-1:0] c_reg, c_next;
    logic [ADDR_W-1:0] r_reg, r_next;
    logic [ADDR_W-1:0] base_reg, base_next;
    logic [ADDR_W-1:0] row_off;
    logic              col_wrap;

    // Wrap/last detection and counter advance.
    always_comb begin
        col_wrap  = (c_reg == C_MAX);
        last_col  = col_wrap && (r_reg == R_MAX);
        col_ge2   = (c_reg >= ADDR_W'(2));
        c_next    = c_reg;
        r_next    = r_reg;
        base_next = base_reg;
        if (advance) begin
            if (last_col) begin
                c_next    = '0;
                r_next    = '0;
                base_next = '0;
            end else if (col_wrap) begin
                c_next    = '0;
                r_next    = r_reg + ADDR_W'(1);
                base_next = base_reg + W_STEP;
            end else begin
                c_next    = c_reg + ADDR_W'(1);
            end
        end
    end

    // addr(r+k, c) = row base + k*IMG_W + c, built from adders only.
    always_comb begin
        case (row_sel)
            2'd1:    row_off = W_STEP;
            2'd2:    row_off = W_STEP + W_STEP;
            default: row_off = '0;
        endcase
        addr = base_next + c_next + row_off;
    end

    // Counter registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            c_reg    <= '0;
            r_reg    <= '0;
            base_reg <= '0;
        end else begin
            c_reg    <= c_next;
            r_reg    <= r_next;
            base_reg <= base_next;
        end
    end

endmodule

// File: rtl/conv_col_feeder.sv
// Column feeder: reads three vertically adjacent pixels per column from the
// sample buffer and pushes each completed column into samp_shift_reg.
module conv_col_feeder
    import conv_pkg::*;
#(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int ADDR_W = $clog2(IMG_W * IMG_H)
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               start,
    input  logic               hold,
    output logic               busy,
    output logic               done,
    conv_col_feeder_if.master  bus
);

    feeder_state_t state_reg, state_next;

    logic [ADDR_W-1:0]   gen_addr;
    logic                last_col;
    logic                col_ge2;
    logic                advance;
    logic [1:0]          row_sel;
    logic                rd_en;
    logic                addr_load;

    logic [ADDR_W-1:0]   rd_addr_reg;
    logic [PIX_BITS-1:0] top_reg;
    logic [PIX_BITS-1:0] mid_reg;
    logic [15:0]         col_out_reg;
    logic                shift_en_reg;
    logic                sample_valid_reg;
    logic                done_reg;

    conv_addr_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk      (clk),
        .n_rst    (n_rst),
        .advance  (advance),
        .row_sel  (row_sel),
        .addr     (gen_addr),
        .last_col (last_col),
        .col_ge2  (col_ge2)
    );

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; hold only matters while waiting in R0.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = R0;
            R0:      if (!hold) state_next = R1;
            R1:      state_next = R2;
            R2:      state_next = CAP;
            CAP:     state_next = last_col ? IDLE : R0;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: read strobe, counter advance and which row the next address targets.
    always_comb begin
        busy      = (state_reg != IDLE);
        rd_en     = ((state_reg == R0) && !hold) || (state_reg == R1) || (state_reg == R2);
        advance   = (state_reg == CAP);
        addr_load = (state_next == R0) || (state_next == R1) || (state_next == R2);
        case (state_next)
            R1:      row_sel = 2'd1;
            R2:      row_sel = 2'd2;
            default: row_sel = 2'd0;
        endcase
    end

    // Address register, pixel capture and the registered push outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rd_addr_reg      <= '0;
            top_reg          <= '0;
            mid_reg          <= '0;
            col_out_reg      <= '0;
            shift_en_reg     <= 1'b0;
            sample_valid_reg <= 1'b0;
            done_reg         <= 1'b0;
        end else begin
            if (addr_load) begin
                rd_addr_reg <= gen_addr;
            end
            if (state_reg == R1) begin
                top_reg <= bus.rd_data;
            end
            if (state_reg == R2) begin
                mid_reg <= bus.rd_data;
            end
            if (state_reg == CAP) begin
                col_out_reg      <= pack_col(top_reg, mid_reg, bus.rd_data);
                shift_en_reg     <= 1'b1;
                sample_valid_reg <= col_ge2;
                done_reg         <= last_col;
            end else begin
                shift_en_reg     <= 1'b0;
                sample_valid_reg <= 1'b0;
                done_reg         <= 1'b0;
            end
        end
    end

    assign bus.rd_en        = rd_en;
    assign bus.rd_addr      = rd_addr_reg;
    assign bus.shift_en     = shift_en_reg;
    assign bus.col_out      = col_out_reg;
    assign bus.sample_valid = sample_valid_reg;
    assign done             = done_reg;

endmodule

// File: tb/tb_conv_col_feeder.sv
// Directed bench for conv_col_feeder: a 4x4 instance and a 3x3 instance.
module tb_conv_col_feeder;
    import conv_pkg::*;

    localparam int AW_A = $clog2(16);
    localparam int AW_B = $clog2(9);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic n_rst;
    logic start_a, hold_a, busy_a, done_a;
    logic start_b, hold_b, busy_b, done_b;

    conv_col_feeder_if #(.ADDR_W(AW_A)) bus_a ();
    conv_col_feeder_if #(.ADDR_W(AW_B)) bus_b ();

    conv_col_feeder #(.IMG_W(4), .IMG_H(4)) dut_a (
        .clk   (clk),
        .n_rst (n_rst),
        .start (start_a),
        .hold  (hold_a),
        .busy  (busy_a),
        .done  (done_a),
        .bus   (bus_a)
    );

    conv_col_feeder #(.IMG_W(3), .IMG_H(3)) dut_b (
        .clk   (clk),
        .n_rst (n_rst),
        .start (start_b),
        .hold  (hold_b),
        .busy  (busy_b),
        .done  (done_b),
        .bus   (bus_b)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Sample buffer: pixel value = low address bits, one cycle after rd_en.
    always @(posedge clk) if (bus_a.rd_en) bus_a.rd_data <= bus_a.rd_addr[3:0];
    always @(posedge clk) if (bus_b.rd_en) bus_b.rd_data <= bus_b.rd_addr[3:0];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Event logs for instance A.
    int          rd_cyc[$];
    logic [3:0]  rd_adr[$];
    int          sh_cyc[$];
    logic [15:0] sh_col[$];
    bit          sh_val[$];
    bit          sh_done[$];
    bit          sh_busy[$];
    int          rd_hold_cnt;
    int          done_cnt_a;
    // Event logs for instance B.
    logic [15:0] b_col[$];
    bit          b_val[$];
    bit          b_done[$];
    int          done_cnt_b;

    always @(negedge clk) begin
        if (bus_a.rd_en) begin
            rd_cyc.push_back(cyc);
            rd_adr.push_back(bus_a.rd_addr);
            if (hold_a) rd_hold_cnt++;
        end
        if (done_a) done_cnt_a++;
        if (bus_a.shift_en) begin
            sh_cyc.push_back(cyc);
            sh_col.push_back(bus_a.col_out);
            sh_val.push_back(bus_a.sample_valid);
            sh_done.push_back(done_a);
            sh_busy.push_back(busy_a);
            $display("[%0d] a push col=%h valid=%0b done=%0b", cyc, bus_a.col_out, bus_a.sample_valid, done_a);
        end
    end

    always @(negedge clk) begin
        if (done_b) done_cnt_b++;
        if (bus_b.shift_en) begin
            b_col.push_back(bus_b.col_out);
            b_val.push_back(bus_b.sample_valid);
            b_done.push_back(done_b);
            $display("[%0d] b push col=%h valid=%0b done=%0b", cyc, bus_b.col_out, bus_b.sample_valid, done_b);
        end
    end

    task automatic clear_logs();
        rd_cyc.delete(); rd_adr.delete();
        sh_cyc.delete(); sh_col.delete(); sh_val.delete(); sh_done.delete(); sh_busy.delete();
        b_col.delete(); b_val.delete(); b_done.delete();
        rd_hold_cnt = 0; done_cnt_a = 0; done_cnt_b = 0;
    endtask

    // Drives start for one cycle; k is the cycle count just before it is sampled.
    task automatic pulse_start_a(output int k);
        @(posedge clk); #1;
        start_a = 1'b1;
        k = cyc;
        @(posedge clk); #1;
        start_a = 1'b0;
    endtask

    // Waits (bounded) for done on A; returns at posedge+1 of the done cycle.
    task automatic wait_done_a(input int budget, output int dcyc);
        bit seen;
        seen = 1'b0;
        dcyc = -1;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk); #1;
            if (done_a) begin
                seen = 1'b1;
                dcyc = cyc;
            end
        end
        check("done_seen_a", {31'd0, seen}, 32'd1);
    endtask

    function automatic logic [15:0] valid_mask_a();
        logic [15:0] m;
        m = '0;
        for (int i = 0; i < sh_val.size() && i < 16; i++) m[i] = sh_val[i];
        return m;
    endfunction

    // Expected 4x4 column word for column index j of a pass.
    function automatic logic [15:0] exp_col_4x4(input int j);
        int top;
        top = (j / 4) * 4 + (j % 4);
        return 16'((top << 8) | ((top + 4) << 4) | (top + 8));
    endfunction

    int k, dc, dc2, n0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_rst = 1'b0;
        start_a = 1'b0; hold_a = 1'b0;
        start_b = 1'b0; hold_b = 1'b0;
        clear_logs();
        repeat (3) @(posedge clk);
        #1;

        // Reset values.
        check("rst_rd_en",   {31'd0, bus_a.rd_en}, 0);
        check("rst_rd_addr", {28'd0, bus_a.rd_addr}, 0);
        check("rst_shift",   {31'd0, bus_a.shift_en}, 0);
        check("rst_col_out", {16'd0, bus_a.col_out}, 0);
        check("rst_valid",   {31'd0, bus_a.sample_valid}, 0);
        check("rst_busy",    {31'd0, busy_a}, 0);
        check("rst_done",    {31'd0, done_a}, 0);

        @(posedge clk); #1;
        n_rst = 1'b1;
        @(posedge clk); #1;

        // Basic 4x4 pass.
        clear_logs();
        pulse_start_a(k);
        wait_done_a(200, dc);
        @(negedge clk); #1;
        check("t1_shift_cnt", sh_cyc.size(), 8);
        check("t1_valid_mask", {16'd0, valid_mask_a()}, 32'h00CC);
        check("t1_col0", {16'd0, sh_col[0]}, 32'h0048);
        check("t1_col1", {16'd0, sh_col[1]}, 32'h0159);
        check("t1_col7", {16'd0, sh_col[7]}, 32'h07BF);
        for (int j = 2; j < 7; j++) check($sformatf("t1_col%0d", j), {16'd0, sh_col[j]}, {16'd0, exp_col_4x4(j)});
        check("t1_done_on_last", {31'd0, sh_done[7]}, 1);
        check("t1_busy_in_done", {31'd0, sh_busy[7]}, 0);
        check("t1_done_cnt", done_cnt_a, 1);
        check("t1_rd_cnt", rd_cyc.size(), 24);
        for (int j = 0; j < 8; j++)
            for (int m = 0; m < 3; m++)
                check($sformatf("t1_addr_c%0d_k%0d", j, m), {28'd0, rd_adr[3*j+m]},
                      ((j / 4) + m) * 4 + (j % 4));
        check("t1_start_to_rd", rd_cyc[0] - k, 1);
        check("t1_rd_to_shift", sh_cyc[0] - rd_cyc[0], 4);
        check("t1_col_period", sh_cyc[1] - sh_cyc[0], 4);
        repeat (3) @(posedge clk);
        #1;
        check("t1_col_hold", {16'd0, bus_a.col_out}, 32'h07BF);
        check("t1_idle_shift", {31'd0, bus_a.shift_en}, 0);

        // Hold of 5 cycles in R0 of the 2nd column.
        clear_logs();
        pulse_start_a(k);
        repeat (4) @(posedge clk);
        #1;
        hold_a = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        hold_a = 1'b0;
        wait_done_a(200, dc);
        @(negedge clk); #1;
        check("t2_rd_in_hold", rd_hold_cnt, 0);
        check("t2_first_shift", sh_cyc[0] - k, 5);
        check("t2_second_delay", sh_cyc[1] - sh_cyc[0], 9);
        check("t2_third_period", sh_cyc[2] - sh_cyc[1], 4);
        check("t2_shift_cnt", sh_cyc.size(), 8);
        check("t2_col1", {16'd0, sh_col[1]}, 32'h0159);
        check("t2_rd_cnt", rd_cyc.size(), 24);

        // start while busy is ignored; start in the done cycle is accepted.
        clear_logs();
        pulse_start_a(k);
        repeat (5) @(posedge clk);
        #1;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        wait_done_a(200, dc);
        start_a = 1'b1;
        n0 = rd_cyc.size();
        @(posedge clk); #1;
        start_a = 1'b0;
        wait_done_a(200, dc2);
        @(negedge clk); #1;
        check("t3_shift_cnt", sh_cyc.size(), 16);
        check("t3_span1", sh_cyc[7] - sh_cyc[0], 28);
        check("t3_done_pass1", {31'd0, sh_done[7]}, 1);
        check("t3_col7", {16'd0, sh_col[7]}, 32'h07BF);
        check("t3_done_cnt", done_cnt_a, 2);
        check("t3_restart_rd", rd_cyc[n0] - dc, 1);
        check("t3_restart_addr", {28'd0, rd_adr[n0]}, 0);
        check("t3_restart_shift", sh_cyc[8] - dc, 5);
        check("t3_span2", sh_cyc[15] - sh_cyc[8], 28);
        check("t3_col15", {16'd0, sh_col[15]}, 32'h07BF);

        // Reset dropped in R2 of the third column.
        clear_logs();
        pulse_start_a(k);
        repeat (10) @(posedge clk);
        #1;
        check("t4_pre_rd_en", {31'd0, bus_a.rd_en}, 1);
        check("t4_pre_addr", {28'd0, bus_a.rd_addr}, 10);
        check("t4_pre_col", {16'd0, bus_a.col_out}, 32'h0159);
        n_rst = 1'b0;
        #1;
        check("t4_rst_rd_en", {31'd0, bus_a.rd_en}, 0);
        check("t4_rst_addr", {28'd0, bus_a.rd_addr}, 0);
        check("t4_rst_shift", {31'd0, bus_a.shift_en}, 0);
        check("t4_rst_col", {16'd0, bus_a.col_out}, 0);
        check("t4_rst_valid", {31'd0, bus_a.sample_valid}, 0);
        check("t4_rst_busy", {31'd0, busy_a}, 0);
        check("t4_rst_done", {31'd0, done_a}, 0);
        @(posedge clk); #1;
        n_rst = 1'b1;
        @(posedge clk); #1;
        clear_logs();
        pulse_start_a(k);
        wait_done_a(200, dc);
        @(negedge clk); #1;
        check("t4_shift_cnt", sh_cyc.size(), 8);
        check("t4_first_addr", {28'd0, rd_adr[0]}, 0);
        check("t4_start_to_rd", rd_cyc[0] - k, 1);
        check("t4_col0", {16'd0, sh_col[0]}, 32'h0048);
        check("t4_col7", {16'd0, sh_col[7]}, 32'h07BF);
        check("t4_valid_mask", {16'd0, valid_mask_a()}, 32'h00CC);
        check("t4_done_cnt", done_cnt_a, 1);

        // Minimum size 3x3.
        clear_logs();
        @(posedge clk); #1;
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        begin
            bit seen_b;
            seen_b = 1'b0;
            for (int i = 0; i < 100 && !seen_b; i++) begin
                @(posedge clk); #1;
                if (done_b) seen_b = 1'b1;
            end
            check("t5_done_seen", {31'd0, seen_b}, 1);
        end
        @(negedge clk); #1;
        check("t5_shift_cnt", b_col.size(), 3);
        check("t5_valid0", {31'd0, b_val[0]}, 0);
        check("t5_valid1", {31'd0, b_val[1]}, 0);
        check("t5_valid2", {31'd0, b_val[2]}, 1);
        check("t5_col0", {16'd0, b_col[0]}, 32'h0036);
        check("t5_col1", {16'd0, b_col[1]}, 32'h0147);
        check("t5_col2", {16'd0, b_col[2]}, 32'h0258);
        check("t5_done_on_last", {31'd0, b_done[2]}, 1);
        check("t5_done_cnt", done_cnt_b, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
